// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline controller.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard equation between the IF/ID consumer and the ID/EX load.
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic             if_id_valid,
  input  logic             id_ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             hazard
);

  // Register $0 is never a real dependency, so a load into it cannot stall.
  assign hazard = if_id_valid & id_ex_valid & ex_mem_read & (ex_rt != '0) &
                  ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, flush and halt/drain sequencing for the five-stage MIPS pipeline.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int REG_W = pipe_pkg::REG_W
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             mem_en,
  output logic             wb_en,
  output logic             halted
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] retire_cnt
`endif
);

  import pipe_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] v_q, v_d;
  logic       stalled_q, stalled_d;
  logic       hazard_s, taken_s, stall_s, fetch_s;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .if_id_valid (v_q[IF_ID]),
    .id_ex_valid (v_q[ID_EX]),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .hazard      (hazard_s)
  );

  // Next valid bits and FSM state; a taken branch outranks a load-use stall.
  always_comb begin
    taken_s   = mem_branch_taken & v_q[EX_MEM];
    stall_s   = hazard_s & ~taken_s & ~stalled_q;
    stalled_d = stall_s;
    case (state_q)
      RUN:     fetch_s = ~taken_s;
      HALTED:  fetch_s = ~halt_req & ~taken_s;
      DRAIN:   fetch_s = 1'b0;
      default: fetch_s = 1'b0;
    endcase
    v_d[MEM_WB] = v_q[EX_MEM];
    v_d[EX_MEM] = v_q[ID_EX] & ~taken_s;
    v_d[ID_EX]  = v_q[IF_ID] & ~stall_s & ~taken_s;
    v_d[IF_ID]  = stall_s ? v_q[IF_ID] : fetch_s;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_req && !stall_s) state_d = DRAIN;
        else                      state_d = RUN;
      end
      DRAIN: begin
        if (v_d == 4'b0000) state_d = HALTED;
        else                state_d = DRAIN;
      end
      HALTED: begin
        if (!halt_req) state_d = RUN;
        else           state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  // Stage-enable and qualification outputs.
  always_comb begin
    pc_sel_branch = taken_s;
    if_id_flush   = taken_s;
    ex_mem_flush  = taken_s;
    id_ex_bubble  = stall_s | taken_s;
    if_id_en      = ~stall_s;
    pc_en         = taken_s | (~stall_s & (state_q == RUN));
    mem_en        = v_q[EX_MEM];
    wb_en         = v_q[MEM_WB];
    halted        = (state_q == HALTED);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      v_q       <= 4'b0000;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      stalled_q <= stalled_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // Event counters, wrapping naturally at 2^CNT_W.
  always_comb begin
    stall_cnt_d  = stall_cnt_q  + (stall_s  ? CNT_W'(1) : CNT_W'(0));
    flush_cnt_d  = flush_cnt_q  + (taken_s  ? CNT_W'(1) : CNT_W'(0));
    retire_cnt_d = retire_cnt_q + (v_q[MEM_WB] ? CNT_W'(1) : CNT_W'(0));
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver queues hand-computed output
// vectors per cycle, and a monitor compares them at the falling edge.
module tb_pipeline_ctrl;

  localparam int REG_W = 5;

  // {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_bubble, ex_mem_flush, mem_en, wb_en, halted}
  localparam logic [8:0] O_IDLE  = 9'b101000000;
  localparam logic [8:0] O_M     = 9'b101000100;
  localparam logic [8:0] O_W     = 9'b101000010;
  localparam logic [8:0] O_MW    = 9'b101000110;
  localparam logic [8:0] O_STALL = 9'b000010110;
  localparam logic [8:0] O_FLUSH = 9'b111111110;
  localparam logic [8:0] O_D_MW  = 9'b001000110;
  localparam logic [8:0] O_D_W   = 9'b001000010;
  localparam logic [8:0] O_HALT  = 9'b001000001;

  typedef struct {
    int          id;
    logic [8:0]  outs;
    bit          cnt_chk;
    int unsigned s_cnt;
    int unsigned f_cnt;
    int unsigned r_cnt;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, ex_mem_read;
  logic             mem_branch_taken, halt_req;
  logic             pc_en, pc_sel_branch, if_id_en, if_id_flush;
  logic             id_ex_bubble, ex_mem_flush, mem_en, wb_en, halted;
`ifdef PERF_CNT_EN
  logic [31:0]      stall_cnt, flush_cnt, retire_cnt;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  pipeline_ctrl #(.REG_W(REG_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rs       (id_uses_rs),
    .id_uses_rt       (id_uses_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .halt_req         (halt_req),
    .pc_en            (pc_en),
    .pc_sel_branch    (pc_sel_branch),
    .if_id_en         (if_id_en),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_flush     (ex_mem_flush),
    .mem_en           (mem_en),
    .wb_en            (wb_en),
    .halted           (halted)
`ifdef PERF_CNT_EN
    , .stall_cnt      (stall_cnt)
    , .flush_cnt      (flush_cnt)
    , .retire_cnt     (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hz: 0 none, 1 rs match, 2 ex_rt=0, 3 rs match but unused, 4 rt match
  task automatic step(input bit rst_v, input bit hr, input bit br, input int hz,
                      input logic [8:0] outs, input bit cc = 1'b0,
                      input int unsigned s = 0, input int unsigned f = 0,
                      input int unsigned r = 0);
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rst_v;
    halt_req         = hr;
    mem_branch_taken = br;
    case (hz)
      1: begin ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1; id_rt = 5'd4; id_uses_rt = 1'b1; end
      2: begin ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1; end
      3: begin ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b0; id_rt = 5'd4; id_uses_rt = 1'b1; end
      4: begin ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_uses_rs = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1; end
      default: begin ex_mem_read = 1'b0; ex_rt = 5'd3; id_rs = 5'd1; id_uses_rs = 1'b1; id_rt = 5'd2; id_uses_rt = 1'b1; end
    endcase
    e.id = step_no; e.outs = outs; e.cnt_chk = cc; e.s_cnt = s; e.f_cnt = f; e.r_cnt = r;
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: pops one expectation per presented cycle.
  initial begin
    exp_t       e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_bubble,
               ex_mem_flush, mem_en, wb_en, halted};
        checks++;
        if (got !== e.outs) begin
          errors++;
          $display("FAIL outs step %0d: got %b expected %b", e.id, got, e.outs);
        end
`ifdef PERF_CNT_EN
        if (e.cnt_chk) begin
          checks++;
          if (stall_cnt !== e.s_cnt || flush_cnt !== e.f_cnt || retire_cnt !== e.r_cnt) begin
            errors++;
            $display("FAIL counters step %0d: got s=%0d f=%0d r=%0d expected s=%0d f=%0d r=%0d",
                     e.id, stall_cnt, flush_cnt, retire_cnt, e.s_cnt, e.f_cnt, e.r_cnt);
          end
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b0; halt_req = 1'b0; mem_branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    // reset values
    step(1'b0, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b0, 1'b0, 1'b0, 0, O_IDLE);
    // fill: v = 0000, 0001, 0011, 0111, 1111
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_M);
    step(1'b1, 1'b0, 1'b0, 0, O_MW);
    // load-use on rs: one stall, inputs still matching next cycle
    step(1'b1, 1'b0, 1'b0, 1, O_STALL);
    step(1'b1, 1'b0, 1'b0, 1, O_MW);
    step(1'b1, 1'b0, 1'b0, 0, O_W);
    step(1'b1, 1'b0, 1'b0, 2, O_M);
    step(1'b1, 1'b0, 1'b0, 3, O_MW);
    // load-use on rt
    step(1'b1, 1'b0, 1'b0, 4, O_STALL);
    step(1'b1, 1'b0, 1'b0, 0, O_MW);
    step(1'b1, 1'b0, 1'b0, 0, O_W);
    step(1'b1, 1'b0, 1'b0, 0, O_M);
    // taken branch with full pipe -> v = 1000
    step(1'b1, 1'b0, 1'b1, 0, O_FLUSH);
    step(1'b1, 1'b0, 1'b0, 0, O_W, 1'b1, 2, 1, 9);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_M);
    // hazard and taken together: flush only
    step(1'b1, 1'b0, 1'b1, 1, O_FLUSH);
    step(1'b1, 1'b0, 1'b0, 1, O_W);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_M);
    // halt with full pipe, drain, then resume
    step(1'b1, 1'b1, 1'b0, 0, O_MW);
    step(1'b1, 1'b1, 1'b0, 0, O_D_MW);
    step(1'b1, 1'b1, 1'b0, 0, O_D_MW);
    step(1'b1, 1'b1, 1'b0, 0, O_D_MW);
    step(1'b1, 1'b1, 1'b0, 0, O_D_W);
    step(1'b1, 1'b1, 1'b0, 0, O_HALT);
    step(1'b1, 1'b1, 1'b0, 0, O_HALT);
    step(1'b1, 1'b0, 1'b0, 0, O_HALT);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_M);
    // halt then reset mid-drain: pipe empties at once
    step(1'b1, 1'b1, 1'b0, 0, O_MW);
    step(1'b1, 1'b1, 1'b0, 0, O_D_MW);
    step(1'b0, 1'b1, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE);
    step(1'b1, 1'b0, 1'b0, 0, O_M);
    // taken + halt + hazard together: flush, then drain
    step(1'b1, 1'b1, 1'b1, 1, O_FLUSH);
    step(1'b1, 1'b1, 1'b0, 0, O_D_W);
    step(1'b1, 1'b1, 1'b0, 0, O_HALT);
    step(1'b1, 1'b0, 1'b0, 0, O_HALT);
    step(1'b1, 1'b0, 1'b0, 0, O_IDLE, 1'b1, 0, 1, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline (fetch, decode, execute, memory, writeBack). It tracks a valid bit per pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards and inserts one bubble, and flushes wrong-path instructions when a branch resolves taken in the memory stage. It gates data-memory writes and register-file writes so that reset-time X values and bubbles never commit state. It also drains and halts the pipeline on request.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, performance-counter width (used only with PERF_CNT_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_rs  in  REG_W  rs field of the instruction in IF/ID
- id_rt  in  REG_W  rt field of the instruction in IF/ID
- id_uses_rs  in  1  the IF/ID instruction reads rs
- id_uses_rt  in  1  the IF/ID instruction reads rt
- ex_mem_read  in  1  MemRead bit of the instruction in ID/EX
- ex_rt  in  REG_W  destination rt of the instruction in ID/EX (load target)
- mem_branch_taken  in  1  Branch & zero of the instruction in EX/MEM
- halt_req  in  1  level; request to stop fetching and drain
- pc_en  out  1  PC register load enable
- pc_sel_branch  out  1  PC mux selects branch address
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  clear IF/ID control bits
- id_ex_bubble  out  1  load zeros into the ID/EX WB/M/EX fields
- ex_mem_flush  out  1  clear the EX/MEM WB/M fields
- mem_en  out  1  qualifies MemWrite/MemRead in the memory stage
- wb_en  out  1  qualifies RegWrite in writeBack
- halted  out  1  pipeline empty and stopped
- stall_cnt, flush_cnt, retire_cnt  out  CNT_W each  present only with PERF_CNT_EN

## Operation
- State register v[3:0]: v0 = IF/ID, v1 = ID/EX, v2 = EX/MEM, v3 = MEM/WB.
- FSM states: RUN, DRAIN, HALTED. One guard flop, stalled_q.
- Definitions:
  - taken = mem_branch_taken & v2.
  - hazard = v0 & v1 & ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
  - stall = hazard & ~taken & ~stalled_q.
- Outputs (combinational from state and inputs):
  - pc_sel_branch = if_id_flush = ex_mem_flush = taken.
  - id_ex_bubble = stall | taken.
  - if_id_en = ~stall.
  - pc_en = taken | (~stall & state == RUN).
  - mem_en = v2.
  - wb_en = v3.
  - halted = (state == HALTED).
- Valid update each cycle:
  - v3 <= v2.
  - v2 <= v1 & ~taken.
  - v1 <= v0 & ~stall & ~taken.
  - v0 <= stall ? v0 : (~taken & state == RUN).
- stalled_q <= stall. At most one bubble is inserted per load-use event, even if the inputs still match.
- Priority: taken over stall. A stalled load-use pair that is flushed is discarded.
- FSM transitions:
  - RUN -> DRAIN when halt_req = 1 and stall = 0. The stall cycle always completes first.
  - DRAIN: no new fetches (v0 shifts in 0). Hazards and flushes are still honoured. A taken branch still loads the PC, but fetch stays off.
  - DRAIN -> HALTED when the next value of v is 0000.
  - HALTED -> RUN when halt_req = 0. The first fetch enters v0 on that transition edge.

## Timing
- Reset (asynchronous, reset = 0):
  - Cleared: v = 0000, state = RUN, stalled_q = 0, counters = 0.
  - Output values during reset: pc_en = 1, if_id_en = 1, mem_en = 0, wb_en = 0, halted = 0, all flush/bubble outputs = 0.
- Reset asserted mid-operation discards all in-flight instructions immediately, with no drain.
- After reset release:
  - The first instruction is valid in IF/ID after edge 1.
  - wb_en first rises after edge 4.
  - Memory and register writes are blocked until then.
- Load-use: stall covers one cycle. The dependent instruction re-decodes the next cycle with stalled_q = 1.
- Taken branch: resolves in EX/MEM. The three younger instructions are killed in that same cycle, and the target is fetched on the next edge. Branch penalty is 3 cycles.
- Simultaneous taken, halt_req, and hazard: the flush applies and the FSM enters DRAIN.
- Drain latency is at most 4 cycles from halt acceptance to halted = 1.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on each stall cycle.
  - flush_cnt increments on each taken cycle.
  - retire_cnt increments on each cycle with wb_en = 1.
  - All three wrap modulo 2^CNT_W and clear on reset.
- PERF_CNT_EN undefined: the counters and their ports are removed, and control behaviour is identical.

## Structure
- Shared package pipe_pkg: FSM state enum (RUN, DRAIN, HALTED), stage-index constants (IF_ID = 0 … MEM_WB = 3), REG_W.
- One sub-module, hazard_detect: the combinational hazard equation, reusable later by a forwarding-aware variant.

## Test plan
- Reset release, halt_req = 0, no hazards → v fills 0001, 0011, 0111, 1111 over edges 1–4; wb_en = 0 until after edge 4.
- lw $9 in ID/EX (ex_mem_read = 1, ex_rt = 9), IF/ID add reads rs = 9 → one cycle with pc_en = 0, if_id_en = 0, id_ex_bubble = 1; next cycle no stall; stall_cnt = 1.
- Same as the previous case but ex_rt = 0, or id_uses_rs = 0 → no stall.
- mem_branch_taken = 1 with v2 = 1 → pc_sel_branch, if_id_flush, id_ex_bubble, ex_mem_flush all 1 for one cycle; next v = 1000 (the branch itself, entering MEM/WB); flush_cnt = 1.
- Hazard and taken in the same cycle → flush only, no stall, stalled_q = 0.
- halt_req = 1 with a full pipe → pc_en = 0 from the next cycle; halted = 1 four cycles later; halt_req = 0 → RUN and v0 = 1 on the next edge; reset = 0 mid-drain → v = 0000 immediately.
